// File: rtl/key_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : key_mode_ctrl
// Description : Front-end for the PWM mode selector. Synchronises and
//               debounces the two raw active-low pushbuttons, emits one pulse
//               per qualified press and holds a one-hot mode level that drives
//               the selector's key0/key1 inputs.
// Ports       : clk       - system clock (50 MHz)
//               rst       - synchronous active-high reset
//               key0_n    - raw KEY0, asynchronous, low = pressed
//               key1_n    - raw KEY1, asynchronous, low = pressed
//               sel0      - mode level to selector key0 (1 in MODE_B)
//               sel1      - mode level to selector key1 (1 in MODE_A)
//               press0/1  - one-cycle pulse on debounced press
//               mode_chg  - one-cycle pulse when the mode actually changes
//               key0_db/1 - debounced key levels, 1 = pressed
// Revision    : 1.0 - initial release
// ============================================================================
module key_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic key0_n,
    input  logic key1_n,
    output logic sel0,
    output logic sel1,
    output logic press0,
    output logic press1,
    output logic mode_chg,
    output logic key0_db,
    output logic key1_db
);

    // Counter value at which the next differing sample completes the
    // qualification window of DEBOUNCE_CYCLES consecutive samples.
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_mode_a = 2'd1;
    localparam logic [1:0] c_st_mode_b = 2'd2;

    logic [1:0] w_key_n;
    logic [1:0] w_db;
    logic [1:0] w_press;

    assign w_key_n = {key1_n, key0_n};

    // ------------------------------------------------------------------
    // Per-key synchroniser, debouncer and press detector
    // ------------------------------------------------------------------
    for (genvar k = 0; k < 2; k++) begin : g_key
        logic             r_sync1;
        logic             r_sync2;
        logic [CNT_W-1:0] r_cnt;
        logic             r_db;
        logic             r_press;
        logic             w_lvl;

        // Pressed level as seen after synchronisation (1 = pressed).
        assign w_lvl = ~r_sync2;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_sync1 <= 1'b1;
                r_sync2 <= 1'b1;
                r_cnt   <= '0;
                r_db    <= 1'b0;
                r_press <= 1'b0;
            end else begin
                r_sync1 <= w_key_n[k];
                r_sync2 <= r_sync1;
                r_press <= 1'b0;
                if (w_lvl == r_db) begin
                    // Any sample agreeing with the accepted level restarts
                    // the qualification, so short glitches are discarded.
                    r_cnt <= '0;
                end else if (r_cnt == c_cnt_last) begin
                    r_db    <= w_lvl;
                    r_cnt   <= '0;
                    // Pulse coincides with the debounced rise; releases
                    // produce no pulse.
                    r_press <= w_lvl;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_db[k]    = r_db;
        assign w_press[k] = r_press;
    end

    assign key0_db = w_db[0];
    assign key1_db = w_db[1];
    assign press0  = w_press[0];
    assign press1  = w_press[1];

    // ------------------------------------------------------------------
    // Mode FSM
    // ------------------------------------------------------------------
    logic [1:0] r_state;
    logic [1:0] w_state_nxt;

    always_comb begin
        w_state_nxt = r_state;
        // Simultaneous presses are ambiguous and therefore ignored.
        if (w_press[1] && !w_press[0]) begin
            w_state_nxt = c_st_mode_a;
        end else if (w_press[0] && !w_press[1]) begin
            w_state_nxt = c_st_mode_b;
        end
    end

    // Outputs are decoded from the next state so that sel and mode_chg
    // land on the same edge as the state update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_st_idle;
            sel0     <= 1'b0;
            sel1     <= 1'b0;
            mode_chg <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            sel0     <= (w_state_nxt == c_st_mode_b);
            sel1     <= (w_state_nxt == c_st_mode_a);
            mode_chg <= (w_state_nxt != r_state);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_key_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_mode_ctrl
// Description : Self-checking bench for key_mode_ctrl. A window-based model
//               predicts every output per clock; a monitor compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_mode_ctrl;

    localparam int D = 8;

    logic clk = 1'b0;
    logic rst;
    logic key0_n;
    logic key1_n;
    logic sel0, sel1, press0, press1, mode_chg, key0_db, key1_db;

    always #5 clk = ~clk;

    key_mode_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .key0_n  (key0_n),
        .key1_n  (key1_n),
        .sel0    (sel0),
        .sel1    (sel1),
        .press0  (press0),
        .press1  (press1),
        .mode_chg(mode_chg),
        .key0_db (key0_db),
        .key1_db (key1_db)
    );

    // Expected output vector {sel0,sel1,press0,press1,mode_chg,key0_db,key1_db}
    logic [6:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // ------------------------------------------------------------------
    // Reference model: a key's debounced level flips once the last D
    // synchronised samples all disagree with it. Mode: 0 idle, 1 A, 2 B.
    // ------------------------------------------------------------------
    bit win0[$];
    bit win1[$];
    bit db[2];
    bit pr[2];
    bit sp1[2];
    bit sp2[2];
    bit rstp;
    bit mchg;
    int mode;

    function automatic bit settled(input int k);
        bit ok;
        int n;
        n  = (k == 0) ? win0.size() : win1.size();
        ok = (n == D);
        for (int i = 0; i < n; i++)
            if (((k == 0) ? win0[i] : win1[i]) == db[k]) ok = 1'b0;
        return ok;
    endfunction

    task automatic model_edge(input bit k0n, input bit k1n, input bit r);
        bit kn[2];
        bit y;
        int nm;
        kn[0] = k0n;
        kn[1] = k1n;
        if (r) begin
            for (int k = 0; k < 2; k++) begin
                db[k] = 0; pr[k] = 0; sp1[k] = 0; sp2[k] = 0;
            end
            win0.delete();
            win1.delete();
            mode = 0;
            mchg = 0;
            rstp = 1;
        end else begin
            nm = mode;
            if (pr[1] && !pr[0]) nm = 1;
            else if (pr[0] && !pr[1]) nm = 2;
            mchg = (nm != mode);
            mode = nm;
            for (int k = 0; k < 2; k++) begin
                // Sample seen by the debouncer was taken two edges ago,
                // or is the released level right after a reset.
                y = rstp ? 1'b0 : sp2[k];
                if (k == 0) begin
                    win0.push_back(y);
                    if (win0.size() > D) void'(win0.pop_front());
                end else begin
                    win1.push_back(y);
                    if (win1.size() > D) void'(win1.pop_front());
                end
                pr[k] = 0;
                if (settled(k)) begin
                    db[k] = ~db[k];
                    pr[k] = db[k];
                end
                sp2[k] = sp1[k];
                sp1[k] = ~kn[k];
            end
            rstp = 0;
        end
        exp_q.push_back({mode == 2, mode == 1, pr[0], pr[1], mchg, db[0], db[1]});
    endtask

    // Drive one input set for n cycles, predicting each edge's outputs.
    task automatic cyc(input bit k0n, input bit k1n, input bit r, input int n);
        repeat (n) begin
            key0_n = k0n;
            key1_n = k1n;
            rst    = r;
            model_edge(k0n, k1n, r);
            @(posedge clk);
            #1;
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    initial begin
        logic [6:0] e;
        logic [6:0] a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {sel0, sel1, press0, press1, mode_chg, key0_db, key1_db};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL outputs t=%0t {sel0,sel1,p0,p1,chg,db0,db1} got %b expected %b",
                             $time, a, e);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int dur;
        bit k0, k1;
        key0_n = 1'b1;
        key1_n = 1'b1;
        rst    = 1'b1;

        cyc(1, 1, 1, 3);            // reset
        cyc(1, 1, 0, 50);           // idle, all outputs low
        cyc(1, 0, 0, 112);          // clean KEY1 press and hold -> MODE_A
        cyc(1, 1, 0, 20);           // release KEY1
        for (int i = 0; i < 10; i++)
            cyc((i % 2 == 0) ? 1'b0 : 1'b1, 1, 0, 3);   // bouncing KEY0
        cyc(0, 1, 0, 20);           // settle low -> MODE_B
        cyc(1, 1, 0, 20);           // release
        cyc(0, 1, 0, 20);           // second KEY0 press: no mode change
        cyc(1, 1, 0, 20);
        cyc(0, 0, 0, 20);           // both on same edge: ignored
        cyc(1, 1, 0, 20);
        cyc(1, 0, 0, 5);            // KEY1 held through a reset
        cyc(1, 0, 1, 1);
        cyc(1, 0, 0, 20);
        cyc(1, 1, 0, 20);

        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(0, 60) == 0) begin
                cyc(1, 1, 1, 1);
            end else begin
                dur = $urandom_range(1, 14);
                k0  = 1'($urandom_range(0, 1));
                k1  = 1'($urandom_range(0, 1));
                cyc(k0, k1, 0, dur);
            end
        end
        cyc(1, 1, 0, 20);

        repeat (4) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain %0d expected vectors left unchecked, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
